// File: rtl/alto_definitions_pkg.sv
// rtl/alto_definitions_pkg.sv - shared Alto constants: memory responder state encodings and counter sizing
package alto_definitions_pkg;

    typedef enum logic [1:0] {
        MR_IDLE = 2'd0,
        MR_WAIT = 2'd1,
        MR_ACK  = 2'd2
    } mr_state_e;

    localparam int MR_CNT_WIDTH = 4;

endpackage

// File: rtl/alto_memory_array.sv
// rtl/alto_memory_array.sv - single-port synchronous RAM, byte-lane write enables, registered read
module alto_memory_array #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [1:0]            sel_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [15:0]           wdata_i,
    output logic [15:0]           rdata_o
);

    logic [15:0] r_mem [0:(2**ADDR_WIDTH)-1];
    logic [15:0] r_rdata;

    // Contents are deliberately left out of reset; only the read register clears.
    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            if (sel_i[1]) r_mem[addr_i][15:8] <= wdata_i[15:8];
            if (sel_i[0]) r_mem[addr_i][7:0]  <= wdata_i[7:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rdata <= 16'h0000;
        end else if (en_i && !we_i) begin
            r_rdata <= r_mem[addr_i];
        end
    end

    assign rdata_o = r_rdata;

endmodule

// File: rtl/alto_memory_responder.sv
// rtl/alto_memory_responder.sv - Wishbone memory responder with programmable wait states
module alto_memory_responder
    import alto_definitions_pkg::*;
#(
    parameter int WAIT_STATES = 1,
    parameter int ADDR_WIDTH  = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [16:1] wb_adr_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [1:0]  wb_sel_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        busy_o
);

    localparam logic [MR_CNT_WIDTH-1:0] LP_WAIT_LOAD = MR_CNT_WIDTH'(WAIT_STATES);

    mr_state_e                 r_state;
    mr_state_e                 w_state_next;
    logic [MR_CNT_WIDTH-1:0]   r_cnt;
    logic [ADDR_WIDTH:1]       r_adr;
    logic                      r_we;
    logic [1:0]                r_sel;
    logic [15:0]               r_dat;
    logic                      w_req;
    logic                      w_ram_en;
    logic                      w_unused_adr;

    assign w_req        = wb_cyc_i & wb_stb_i;
    assign w_unused_adr = ^wb_adr_i;

    // RAM fires only on the last wait cycle, with the initiator still present and no reset.
    assign w_ram_en = rst_ni && (r_state == MR_WAIT) && (r_cnt == '0) && w_req;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= MR_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            MR_IDLE: if (w_req) w_state_next = MR_WAIT;
            MR_WAIT: begin
                if (!w_req)             w_state_next = MR_IDLE;
                else if (r_cnt == '0)   w_state_next = MR_ACK;
            end
            MR_ACK:  w_state_next = MR_IDLE;
            default: w_state_next = MR_IDLE;
        endcase
    end

    always_comb begin
        wb_ack_o = (r_state == MR_ACK);
        busy_o   = (r_state != MR_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_cnt <= '0;
            r_adr <= '0;
            r_we  <= 1'b0;
            r_sel <= 2'b00;
            r_dat <= 16'h0000;
        end else if (r_state == MR_IDLE && w_req) begin
            r_cnt <= LP_WAIT_LOAD;
            r_adr <= wb_adr_i[ADDR_WIDTH:1];
            r_we  <= wb_we_i;
            r_sel <= wb_sel_i;
            r_dat <= wb_dat_i;
        end else if (r_state == MR_WAIT && w_req && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    alto_memory_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (w_ram_en),
        .we_i    (r_we),
        .sel_i   (r_sel),
        .addr_i  (r_adr),
        .wdata_i (r_dat),
        .rdata_o (wb_dat_o)
    );

endmodule

// File: tb/tb_alto_memory_responder.sv
// tb/tb_alto_memory_responder.sv - randomized self-checking bench for alto_memory_responder
module tb_alto_memory_responder;

    logic        clk = 1'b0;
    logic        rst_n [2];
    logic        cyc   [2];
    logic        stb   [2];
    logic        we    [2];
    logic [16:1] adr   [2];
    logic [1:0]  sel   [2];
    logic [15:0] wdat  [2];
    logic [15:0] rdat  [2];
    logic        ack   [2];
    logic        busy  [2];

    int n_pass  = 0;
    int n_total = 0;
    logic [15:0] model [0:255];

    always #5 clk = ~clk;

    // d=0: no wait states, full 16-bit decode; d=1: three wait states, 8-bit decode
    alto_memory_responder #(.WAIT_STATES(0), .ADDR_WIDTH(16)) dut0 (
        .clk_i(clk), .rst_ni(rst_n[0]), .wb_adr_i(adr[0]), .wb_cyc_i(cyc[0]),
        .wb_stb_i(stb[0]), .wb_we_i(we[0]), .wb_sel_i(sel[0]), .wb_dat_i(wdat[0]),
        .wb_dat_o(rdat[0]), .wb_ack_o(ack[0]), .busy_o(busy[0]));

    alto_memory_responder #(.WAIT_STATES(3), .ADDR_WIDTH(8)) dut1 (
        .clk_i(clk), .rst_ni(rst_n[1]), .wb_adr_i(adr[1]), .wb_cyc_i(cyc[1]),
        .wb_stb_i(stb[1]), .wb_we_i(we[1]), .wb_sel_i(sel[1]), .wb_dat_i(wdat[1]),
        .wb_dat_o(rdat[1]), .wb_ack_o(ack[1]), .busy_o(busy[1]));

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_txn(input int d, input logic w, input logic [16:1] a, input logic [1:0] s,
                          input logic [15:0] dt, input bit scramble,
                          output int lat, output logic [15:0] rd);
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; sel[d] = s; wdat[d] = dt;
        lat = 0;
        rd  = 16'h0000;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (ack[d]) begin
                lat = n;
                rd  = rdat[d];
                break;
            end
            if (scramble) begin
                adr[d] = 16'($urandom); wdat[d] = 16'($urandom);
                sel[d] = 2'($urandom);  we[d]   = 1'($urandom);
            end
        end
        cyc[d] = 1'b0; stb[d] = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
            adr[d] = '0; sel[d] = 2'b00; wdat[d] = 16'h0000;
        end
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (ack[d] !== 1'b0) $display("FAIL reset_ack d%0d got %b want 0", d, ack[d]); else n_pass++;
            n_total++;
            if (busy[d] !== 1'b0) $display("FAIL reset_busy d%0d got %b want 0", d, busy[d]); else n_pass++;
            n_total++;
            if (rdat[d] !== 16'h0000) $display("FAIL reset_dat d%0d got %h want 0000", d, rdat[d]); else n_pass++;
        end
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        tick();
    endtask

    task automatic test_latency_rw();
        int lat;
        logic [15:0] rd;
        for (int d = 0; d < 2; d++) begin
            do_txn(d, 1'b1, 16'o000100, 2'b11, 16'o123456, 1'b0, lat, rd);
            n_total++;
            if (lat != ws_of(d) + 2) $display("FAIL wr_latency d%0d got %0d want %0d", d, lat, ws_of(d) + 2); else n_pass++;
            n_total++;
            if (ack[d] !== 1'b0 || busy[d] !== 1'b0) $display("FAIL ack_width d%0d got ack=%b busy=%b want 0 0", d, ack[d], busy[d]); else n_pass++;
            do_txn(d, 1'b0, 16'o000100, 2'b11, 16'h0000, 1'b0, lat, rd);
            n_total++;
            if (lat != ws_of(d) + 2) $display("FAIL rd_latency d%0d got %0d want %0d", d, lat, ws_of(d) + 2); else n_pass++;
            n_total++;
            if (rd !== 16'o123456) $display("FAIL rd_data d%0d got %o want 123456", d, rd); else n_pass++;
        end
        do_txn(0, 1'b1, 16'h0200, 2'b11, 16'h9999, 1'b0, lat, rd);
        n_total++;
        if (rdat[0] !== 16'o123456) $display("FAIL dat_hold_on_write got %o want 123456", rdat[0]); else n_pass++;
    endtask

    task automatic test_byte_lanes();
        int lat;
        logic [15:0] rd;
        do_txn(1, 1'b1, 16'h0011, 2'b11, 16'hABCD, 1'b0, lat, rd);
        do_txn(1, 1'b1, 16'h0011, 2'b10, 16'h1200, 1'b0, lat, rd);
        do_txn(1, 1'b0, 16'h0011, 2'b11, 16'h0000, 1'b0, lat, rd);
        n_total++;
        if (rd !== 16'h12CD) $display("FAIL byte_lane_hi got %h want 12CD", rd); else n_pass++;
        do_txn(1, 1'b1, 16'h0011, 2'b01, 16'hEE34, 1'b0, lat, rd);
        do_txn(1, 1'b1, 16'h0011, 2'b00, 16'h7777, 1'b0, lat, rd);
        n_total++;
        if (lat != 5) $display("FAIL sel00_ack got latency %0d want 5", lat); else n_pass++;
        do_txn(1, 1'b0, 16'h0011, 2'b11, 16'h0000, 1'b0, lat, rd);
        n_total++;
        if (rd !== 16'h1234) $display("FAIL byte_lane_lo_sel00 got %h want 1234", rd); else n_pass++;
    endtask

    task automatic test_aliasing();
        int lat;
        logic [15:0] rd;
        do_txn(1, 1'b1, 16'h0103, 2'b11, 16'h0042, 1'b0, lat, rd);
        do_txn(1, 1'b0, 16'h0003, 2'b11, 16'h0000, 1'b0, lat, rd);
        n_total++;
        if (rd !== 16'h0042) $display("FAIL alias_aw8 got %h want 0042", rd); else n_pass++;
        do_txn(0, 1'b1, 16'h0103, 2'b11, 16'h1111, 1'b0, lat, rd);
        do_txn(0, 1'b1, 16'h0003, 2'b11, 16'h2222, 1'b0, lat, rd);
        do_txn(0, 1'b0, 16'h0103, 2'b11, 16'h0000, 1'b0, lat, rd);
        n_total++;
        if (rd !== 16'h1111) $display("FAIL no_alias_aw16 got %h want 1111", rd); else n_pass++;
    endtask

    task automatic test_abort();
        int lat;
        int acks;
        logic [15:0] rd;
        do_txn(1, 1'b1, 16'h0005, 2'b11, 16'h0BAD, 1'b0, lat, rd);
        // abort after one wait cycle, then abort exactly in the RAM-enable cycle
        for (int drop_at = 1; drop_at <= 4; drop_at += 3) begin
            cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 16'h0005; sel[1] = 2'b11; wdat[1] = 16'hFFFF;
            acks = 0;
            repeat (drop_at) begin
                tick();
                if (ack[1]) acks++;
            end
            stb[1] = 1'b0;
            repeat (6) begin
                tick();
                if (ack[1]) acks++;
            end
            cyc[1] = 1'b0;
            n_total++;
            if (acks != 0) $display("FAIL abort_noack drop%0d got %0d acks want 0", drop_at, acks); else n_pass++;
            n_total++;
            if (busy[1] !== 1'b0) $display("FAIL abort_idle drop%0d got busy=%b want 0", drop_at, busy[1]); else n_pass++;
            do_txn(1, 1'b0, 16'h0005, 2'b11, 16'h0000, 1'b0, lat, rd);
            n_total++;
            if (rd !== 16'h0BAD) $display("FAIL abort_nowrite drop%0d got %h want 0BAD", drop_at, rd); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_wait();
        int lat;
        logic [15:0] rd;
        do_txn(1, 1'b1, 16'h0007, 2'b11, 16'h0777, 1'b0, lat, rd);
        do_txn(1, 1'b0, 16'h0007, 2'b11, 16'h0000, 1'b0, lat, rd);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 16'h0007; sel[1] = 2'b11; wdat[1] = 16'h5555;
        repeat (4) tick();
        rst_n[1] = 1'b0;
        tick();
        n_total++;
        if (ack[1] !== 1'b0 || busy[1] !== 1'b0) $display("FAIL rst_mid_wait_ctrl got ack=%b busy=%b want 0 0", ack[1], busy[1]); else n_pass++;
        n_total++;
        if (rdat[1] !== 16'h0000) $display("FAIL rst_mid_wait_dat got %h want 0000", rdat[1]); else n_pass++;
        rst_n[1] = 1'b1; cyc[1] = 1'b0; stb[1] = 1'b0;
        tick();
        do_txn(1, 1'b0, 16'h0007, 2'b11, 16'h0000, 1'b0, lat, rd);
        n_total++;
        if (rd !== 16'h0777) $display("FAIL rst_mid_wait_ram got %h want 0777", rd); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [5:0] seen;
        logic [15:0] rd5;
        seen = '0;
        rd5  = 16'h0000;
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 16'h0321; sel[0] = 2'b11; wdat[0] = 16'hC0DE;
        for (int c = 1; c <= 6; c++) begin
            tick();
            seen[c-1] = ack[0];
            if (c == 2) we[0] = 1'b0;
            if (c == 5) begin
                rd5 = rdat[0];
                cyc[0] = 1'b0; stb[0] = 1'b0;
            end
        end
        n_total++;
        if (seen !== 6'b010010) $display("FAIL b2b_ack_pattern got %b want 010010 (cycle6..1)", seen); else n_pass++;
        n_total++;
        if (rd5 !== 16'hC0DE) $display("FAIL b2b_read got %h want C0DE", rd5); else n_pass++;
    endtask

    task automatic test_random();
        int lat;
        int errs;
        logic [15:0] rd;
        logic [15:0] dt;
        logic [16:1] a;
        logic [1:0]  s;
        logic        w;
        for (int i = 0; i < 256; i++) begin
            dt = 16'($urandom);
            do_txn(1, 1'b1, 16'(i), 2'b11, dt, 1'b0, lat, rd);
            model[i] = dt;
        end
        errs = 0;
        for (int i = 0; i < 120; i++) begin
            a  = 16'($urandom);
            dt = 16'($urandom);
            s  = 2'($urandom);
            w  = 1'($urandom);
            do_txn(1, w, a, s, dt, 1'b1, lat, rd);
            n_total++;
            if (lat != 5) $display("FAIL rand_latency op%0d got %0d want 5", i, lat); else n_pass++;
            if (w) begin
                if (s[1]) model[int'(a) % 256][15:8] = dt[15:8];
                if (s[0]) model[int'(a) % 256][7:0]  = dt[7:0];
            end else begin
                n_total++;
                if (rd !== model[int'(a) % 256]) $display("FAIL rand_read op%0d adr %h got %h want %h", i, a, rd, model[int'(a) % 256]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency_rw();
        test_byte_lanes();
        test_aliasing();
        test_abort();
        test_reset_mid_wait();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
